// File: rtl/pressure_pulse_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pressure_pulse_gen_if
//  Brief    : Request inputs and slider outputs of the pressure pulse
//             generator. The master side requests bursts and watches the
//             slider lines; the slave side is the generator itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface pressure_pulse_gen_if #(
  parameter int CNT_W = 8
);
  // Burst request
  logic             start;
  logic [1:0]       level;
  logic [CNT_W-1:0] pulse_count;
  logic             abort;

  // Slider lines and status
  logic             slider;
  logic             slider2;
  logic             slider3;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_sent;

  modport master (
    output start, level, pulse_count, abort,
    input  slider, slider2, slider3, busy, done, pulses_sent
  );

  modport slave (
    input  start, level, pulse_count, abort,
    output slider, slider2, slider3, busy, done, pulses_sent
  );
endinterface
`default_nettype wire

// File: rtl/pressure_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pressure_pulse_gen
//  Brief    : Emulates the pressure-sensor sliders. Emits a burst of N pulses
//             on slider (HIGH_CYC high, LOW_CYC low each) while slider2 and
//             slider3 hold a thermometer code of the latched level. All
//             outputs come straight from flops.
//  Revision : 1.0 - initial release
// ============================================================================
module pressure_pulse_gen #(
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4,
  parameter int CNT_W    = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pressure_pulse_gen_if.slave   bus
);

  localparam int c_max_cyc = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int c_ph_w    = $clog2(c_max_cyc + 1);

  // The phase counter counts down to zero, so each phase loads its length-1.
  localparam logic [c_ph_w-1:0] c_high_load = c_ph_w'(HIGH_CYC - 1);
  localparam logic [c_ph_w-1:0] c_low_load  = c_ph_w'(LOW_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [c_ph_w-1:0]  ph_q,      ph_d;
  logic [1:0]         lvl_q,     lvl_d;
  logic [CNT_W-1:0]   neff_q,    neff_d;
  logic [CNT_W-1:0]   sent_q,    sent_d;
  logic               slider_q,  slider_d;
  logic               slider2_q, slider2_d;
  logic               slider3_q, slider3_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  // Level 0 means "no pressure": the burst collapses to zero pulses.
  logic [CNT_W-1:0]   w_neff;
  // One more pulse still to go after the current one completes.
  logic               w_more;

  assign w_neff = (bus.level == 2'd0) ? '0 : bus.pulse_count;
  // Widened by one bit so the compare stays exact at the full-scale count.
  assign w_more = (({1'b0, sent_q} + 1'b1) < {1'b0, neff_q});

  // Next-state, phase timing and registered-output values.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    lvl_d   = lvl_q;
    neff_d  = neff_q;
    sent_d  = sent_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort outranks start, so a simultaneous pair is a no-op.
        if (bus.start && !bus.abort) begin
          lvl_d  = bus.level;
          neff_d = w_neff;
          sent_d = '0;
          if (w_neff != '0) begin
            state_d = S_HIGH;
            ph_d    = c_high_load;
          end else begin
            done_d  = 1'b1;
          end
        end
      end

      S_HIGH: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (ph_q == '0) begin
          state_d = S_LOW;
          ph_d    = c_low_load;
        end else begin
          ph_d    = ph_q - 1'b1;
        end
      end

      S_LOW: begin
        if (bus.abort) begin
          // Completed-pulse count is kept; the partial pulse is not counted.
          state_d = S_IDLE;
        end else if (ph_q == '0) begin
          sent_d = sent_q + 1'b1;
          if (w_more) begin
            state_d = S_HIGH;
            ph_d    = c_high_load;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear in the cycle the
    // new state takes effect, yet still leave the chip from flops.
    busy_d    = (state_d != S_IDLE);
    slider_d  = (state_d == S_HIGH);
    slider2_d = busy_d && lvl_d[1];
    slider3_d = busy_d && (lvl_d == 2'd3);
  end

  // State, counters and output flops; reset drops every line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      lvl_q     <= '0;
      neff_q    <= '0;
      sent_q    <= '0;
      slider_q  <= 1'b0;
      slider2_q <= 1'b0;
      slider3_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      lvl_q     <= lvl_d;
      neff_q    <= neff_d;
      sent_q    <= sent_d;
      slider_q  <= slider_d;
      slider2_q <= slider2_d;
      slider3_q <= slider3_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.slider      = slider_q;
  assign bus.slider2     = slider2_q;
  assign bus.slider3     = slider3_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = sent_q;

endmodule
`default_nettype wire

// File: doc/pressure_pulse_gen.md
Name: pressure_pulse_gen

Overview:
- Transmit-side emulator for the pressure-sensor front end: drives the three slider lines the pressure input block consumes.
- `slider` carries a burst of N pulses; the pressure input block counts these on its rising edges.
- `slider2` and `slider3` are static thermometer levels held for the whole burst.
- Used for bench and board self-test of the pressure input path, replacing the physical sliders.

Parameters:
- HIGH_CYC, 4, clock cycles `slider` is high per pulse (>=1).
- LOW_CYC, 4, clock cycles `slider` is low after each pulse (>=1).
- CNT_W, 8, width of pulse-count request and pulses_sent.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request burst; accepted only in IDLE.
- level  input  2  pressure level 0..3, latched on accept.
- pulse_count  input  CNT_W  pulses to emit, latched on accept.
- abort  input  1  terminate burst immediately.
- slider  output  1  pulse train line.
- slider2  output  1  thermometer bit: latched level>=2, held while busy.
- slider3  output  1  thermometer bit: latched level==3, held while busy.
- busy  output  1  burst in progress.
- done  output  1  one-cycle completion strobe.
- pulses_sent  output  CNT_W  completed pulses in current/last burst.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, latched level/count 0.
- Registered outputs: every output is a registered (flop) output; no combinational path from inputs to outputs.
- States: IDLE, HIGH, LOW.
- Effective count: N_eff = 0 if level==0, else pulse_count.
- IDLE:
  - On start=1 at edge T with abort=0: latch level and N_eff, pulses_sent<=0.
  - If N_eff>0: go to HIGH; at T+1 slider=1, busy=1, slider2/slider3 per latched level.
  - If N_eff==0: stay IDLE; done=1 at T+1 only, no busy, no slider activity.
- HIGH: slider=1 for exactly HIGH_CYC cycles, then LOW.
- LOW:
  - slider=0 for exactly LOW_CYC cycles.
  - pulses_sent increments at the edge leaving LOW.
  - If pulses_sent+1 < N_eff: back to HIGH.
  - Else: IDLE with done=1, busy=0, slider2=slider3=0 in that same cycle.
- Timing: burst of N pulses keeps busy high for exactly N*(HIGH_CYC+LOW_CYC) cycles; done lands at T+1+N*(HIGH_CYC+LOW_CYC).
- done: high for exactly one cycle per completed burst; never asserted on abort.
- start while busy: ignored, and inputs are not re-latched.
- start and done in the same cycle: start is accepted, since the FSM is already IDLE.
- abort while busy:
  - Next cycle goes to IDLE with slider=0, slider2=slider3=0, busy=0, done=0.
  - pulses_sent holds the completed-pulse count.
  - abort in IDLE has no effect; abort has priority over start.
- Phase counter: sized clog2(max(HIGH_CYC,LOW_CYC)+1); reloaded on every phase entry.
- Pulse count: pulse_count = 2^CNT_W-1 is legal; there is no wrap, because termination compares against latched N_eff.
- Reset mid-burst: outputs return to 0 asynchronously; nothing resumes after release.
- pulses_sent: holds its value after done until the next accepted start.

Test Plan:
1. HIGH_CYC=4, LOW_CYC=4, level=3, pulse_count=3, start at T -> slider high T+1..T+4, T+9..T+12, T+17..T+20; slider2=slider3=1 and busy=1 T+1..T+24; done=1 at T+25 only; pulses_sent=3.
2. level=1, pulse_count=2 -> two slider pulses, slider2=slider3=0 throughout, done at T+17, pulses_sent=2.
3. level=0, pulse_count=5 (and separately level=2, pulse_count=0) -> no slider activity, busy never high, done=1 at T+1, pulses_sent=0.
4. start re-pulsed with level=0 at T+6 during a level=3/count=3 burst -> ignored; burst completes exactly as in scenario 1.
5. abort at T+10 in a level=3/count=3 burst -> at T+11 all lines 0, busy=0, done never asserts, pulses_sent=1; a new start at T+12 is accepted.
6. rst_n low at T+6 mid-burst -> outputs 0 immediately (before next clk edge), stays IDLE after release until a new start.
